// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types for the stopwatch sequencer.
//   mode_t : sequencer state, also driven on the mode LEDs
//   bcd4_t : four packed BCD digits {d3,d2,d1,d0}
package stopwatch_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SPLIT  = 3'd2,
    STOP   = 3'd3,
    RECALL = 3'd4
  } mode_t;

  typedef logic [15:0] bcd4_t;

endpackage

// File: rtl/lap_buffer.sv
// lap_buffer: DEPTH x 16-bit lap time store.
//   clk, rst  : clock, synchronous active-high reset (clears count only)
//   clr       : synchronous clear of the count
//   wr_en     : append wr_data at slot 'count' (ignored when full)
//   wr_data   : lap time to store
//   rd_idx    : combinational read index
//   rd_data   : entry at rd_idx
//   count     : number of stored laps (0..DEPTH)
//   full      : count == DEPTH
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  bcd4_t         wr_data,
  input  logic [IW-1:0] rd_idx,
  output bcd4_t         rd_data,
  output logic [IW:0]   count,
  output logic          full
);

  bcd4_t mem [DEPTH];

  assign full    = (count == (IW+1)'(DEPTH));
  assign rd_data = mem[rd_idx];

  // The write pointer is the count itself; it only fits IW bits while
  // not full, which is exactly when a write is allowed.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[count[IW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (wr_en && !full) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// stopwatch_mode_ctrl: stopwatch sequencer (start/stop, split, lap recall).
//   clk, rst  : divided clock, synchronous active-high reset
//   start_go, lap_go, clr_go : single-cycle button pulses
//   time_bcd  : live counter value
//   cnt_en    : counter enable (registered)
//   cnt_clr   : one-cycle counter clear (registered)
//   disp_bcd  : value for the seven-segment display
//   lap_idx   : recalled lap index
//   lap_cnt   : laps stored, lap_full : buffer full
//   mode      : current state encoding (also the FSM debug view)
//
// Input protocol: the *_go inputs are fire-and-forget pulses with no ready;
// each is acted on in the cycle it is high. When several are high at once
// clr_go wins over start_go, which wins over lap_go; the losers are dropped.
module stopwatch_mode_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = 3000,
  parameter int IW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_go,
  input  logic              lap_go,
  input  logic              clr_go,
  input  bcd4_t             time_bcd,
  output logic              cnt_en,
  output logic              cnt_clr,
  output bcd4_t             disp_bcd,
  output logic [IW-1:0]     lap_idx,
  output logic [IW:0]       lap_cnt,
  output logic              lap_full,
  output logic [MODE_W-1:0] mode
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  mode_t         state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [IW-1:0] idx_nxt;
  bcd4_t         frozen;
  bcd4_t         rd_data;
  logic          capture;

  lap_buffer #(.DEPTH(DEPTH), .IW(IW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_go),
    .wr_en   (capture),
    .wr_data (time_bcd),
    .rd_idx  (lap_idx),
    .rd_data (rd_data),
    .count   (lap_cnt),
    .full    (lap_full)
  );

  // Next-state decode. The hold timer is zero outside SPLIT, so any entry
  // into SPLIT starts a fresh hold period.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    idx_nxt   = lap_idx;
    capture   = 1'b0;
    if (clr_go) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_go) state_nxt = RUN;
        end
        RUN: begin
          if (start_go) begin
            state_nxt = STOP;
          end else if (lap_go) begin
            state_nxt = SPLIT;
            capture   = 1'b1;
          end
        end
        SPLIT: begin
          if (start_go) begin
            state_nxt = STOP;
          end else if (lap_go) begin
            capture = 1'b1;
          end else if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state_nxt = RUN;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        STOP: begin
          if (start_go) begin
            state_nxt = RUN;
          end else if (lap_go && lap_cnt != '0) begin
            state_nxt = RECALL;
            idx_nxt   = '0;
          end
        end
        RECALL: begin
          if (start_go) begin
            state_nxt = STOP;
            idx_nxt   = '0;
          end else if (lap_go) begin
            // lap_cnt is non-zero here: RECALL is only entered with laps stored.
            if ({1'b0, lap_idx} == lap_cnt - 1'b1) idx_nxt = '0;
            else                                   idx_nxt = lap_idx + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_idx  <= '0;
      hold_cnt <= '0;
      frozen   <= '0;
    end else begin
      state    <= state_nxt;
      cnt_en   <= (state_nxt == RUN) || (state_nxt == SPLIT);
      cnt_clr  <= clr_go;
      lap_idx  <= idx_nxt;
      hold_cnt <= hold_nxt;
      // Frozen value follows every capture, even when the buffer is full.
      if (capture) frozen <= time_bcd;
    end
  end

  always_comb begin
    case (state)
      SPLIT:   disp_bcd = frozen;
      RECALL:  disp_bcd = rd_data;
      default: disp_bcd = time_bcd;
    endcase
  end

  assign mode = state;

endmodule

// File: doc/stopwatch_mode_ctrl.md
Name: stopwatch_mode_ctrl

Overview:
Central sequencer for the stopwatch datapath. It consumes the debounced, single-pulsed start/lap/clear buttons and the live 4-digit BCD time from the BCD counter. It drives the counter enable and clear, and stores up to DEPTH lap times in an internal buffer. It selects what the seven-segment controller shows: live time, a frozen split, or a recalled lap. It runs on the divided clock, in place of the start/stop FSM and the lap-capture logic.

Parameters:
DEPTH, 8, number of lap entries stored (power of 2, 2..16)
HOLD_CYC, 3000, clk cycles the split display stays frozen before returning to live time
IW, $clog2(DEPTH), width of the lap index

Ports:
clk  in  1  divided system clock
rst  in  1  reset, synchronous, active-high
start_go  in  1  single-cycle start/stop pulse
lap_go  in  1  single-cycle lap pulse
clr_go  in  1  single-cycle clear pulse
time_bcd  in  16  live counter value {d3,d2,d1,d0}
cnt_en  out  1  counter enable
cnt_clr  out  1  one-cycle counter clear
disp_bcd  out  16  value to display {d3,d2,d1,d0}
lap_idx  out  IW  index of the lap being recalled
lap_cnt  out  IW+1  number of laps stored (0..DEPTH)
lap_full  out  1  lap_cnt == DEPTH
mode  out  3  current state encoding (drives mode LEDs/dp)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; cnt_en=0, cnt_clr=0, lap_cnt=0, lap_idx=0, lap_full=0.
  - Hold timer=0, frozen register=0. Buffer contents are don't-care.
- All pulses are sampled at the clk edge. Next state and registered outputs are visible the following cycle (1-cycle latency).
- Priority when pulses coincide: clr_go > start_go > lap_go. Lower-priority pulses in the same cycle are dropped.
- States:
  - IDLE: start -> RUN. lap ignored. clr -> IDLE.
  - RUN: start -> STOP. lap -> capture, then SPLIT.
  - SPLIT: counting continues with the display frozen. lap -> capture again, hold timer restarts, stay in SPLIT. start -> STOP. Hold timer reaching HOLD_CYC-1 -> RUN.
  - STOP: start -> RUN. lap -> RECALL with lap_idx=0 if lap_cnt>0, otherwise ignored.
  - RECALL: lap -> lap_idx increments, wrapping to 0 after lap_cnt-1. start -> STOP, with lap_idx reset to 0.
  - clr from any non-IDLE state -> IDLE.
- Capture:
  - Writes time_bcd as sampled in the lap_go cycle into buf[lap_cnt] and increments lap_cnt, only if not lap_full.
  - The frozen register loads time_bcd on every capture, even when the buffer is full. The display freezes, but nothing is stored or overwritten.
- clr_go effects:
  - cnt_clr pulses high for exactly one cycle (the cycle after clr_go).
  - lap_cnt=0, lap_idx=0, hold timer=0.
  - clr_go in IDLE still pulses cnt_clr.
- Outputs by state:
  - cnt_en is registered: 1 exactly when the next state is RUN or SPLIT.
  - disp_bcd is combinational on registered state: IDLE/RUN/STOP show time_bcd; SPLIT shows the frozen register; RECALL shows buf[lap_idx].
- mode encoding: IDLE=0, RUN=1, SPLIT=2, STOP=3, RECALL=4. Unused codes go to IDLE on the next edge.
- Hold timer: counts only in SPLIT. Width is $clog2(HOLD_CYC). Saturation is not needed because the timer exits SPLIT first.
- Counter wrap (9999 -> 0000) belongs to the datapath. This block passes the value through unchanged.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef enum logic [2:0] mode_t {IDLE, RUN, SPLIT, STOP, RECALL}
  - typedef logic [15:0] bcd4_t
  - constant MODE_W=3
- Sub-module lap_buffer: DEPTH x 16 register file with write enable, write pointer, combinational read by index, count and full outputs, and a synchronous clear. The FSM, hold timer and display mux stay in the top module.

Test Plan:
- Reset then start_go -> cnt_en=1 one cycle later, mode=1. Second start_go -> cnt_en=0, mode=3.
- RUN with time_bcd=0x0123, lap_go -> buf[0]=0x0123, lap_cnt=1, mode=2, disp_bcd=0x0123 while time_bcd changes. After HOLD_CYC cycles -> mode=1, disp_bcd=time_bcd.
- Capture 0x0010, 0x0020, 0x0030, then stop and press lap 4 times -> disp_bcd sequence 0x0010, 0x0020, 0x0030, 0x0010, lap_idx sequence 0,1,2,0. start_go -> mode=3, live display.
- DEPTH+1 laps -> lap_full=1, lap_cnt=DEPTH, buf[DEPTH-1] unchanged by the extra lap, frozen display shows the last sampled time.
- clr_go, start_go and lap_go in the same cycle while in RUN -> mode=0, cnt_en=0, cnt_clr high for exactly 1 cycle, lap_cnt=0.
- rst asserted mid-SPLIT with lap_cnt=3 -> next cycle mode=0, cnt_en=0, lap_cnt=0, disp_bcd=time_bcd. In STOP with lap_cnt=0, lap_go -> stays mode=3.
